refresh_control: RTL and testbench

- Periodic DDR refresh scheduler; sits beside init_control and the transaction scheduler in the core_clk domain.
- Starts after ddr_init_done, counts tREFI intervals and tracks owed refreshes up to the JEDEC postponement limit.
- Requests the shared DFI command path from the command arbiter, then issues precharge-all followed by one or more REF commands, honouring tRP and tRFC.

---
 rtl/refresh_control.sv | 144 ++++++++++++++
 tb/tb_refresh_control.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/refresh_control.sv
// Periodic DDR refresh scheduler: counts tREFI intervals, tracks owed refreshes
// and issues PREA followed by one or more REF commands over the shared DFI path.
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | nothing owed, or refresh disabled
// REQ      | requesting the DFI command path, waiting for grant
// PREA     | precharge-all valid, waiting for ready
// WAIT_RP  | tRP wait after PREA accept
// REF      | refresh valid, waiting for ready
// WAIT_RFC | tRFC wait after REF accept, then next REF or back to IDLE
module refresh_control #(
  parameter int TREFI_CLK    = 6240,
  parameter int TRP_CLK      = 11,
  parameter int TRFC_CLK     = 208,
  parameter int MAX_POSTPONE = 8,
  parameter int URGENT_TH    = 4,
  localparam int PEND_W      = $clog2(MAX_POSTPONE + 2)
) (
  input  logic              core_clk,
  input  logic              core_arst,
  input  logic              ddr_init_done,
  output logic              ref_req,
  output logic              ref_urgent,
  input  logic              ref_gnt,
  output logic              ref_cmd_valid,
  output logic              ref_cmd_type,
  input  logic              ref_cmd_ready,
  output logic [PEND_W-1:0] ref_pending,
  output logic              ref_overflow
);

  localparam int CNT_W    = $clog2(TREFI_CLK);
  localparam int WAIT_MAX = (TRP_CLK > TRFC_CLK) ? TRP_CLK : TRFC_CLK;
  localparam int WAIT_W   = $clog2(WAIT_MAX + 1);

  localparam logic [CNT_W-1:0]  TREFI_LAST = CNT_W'(TREFI_CLK - 1);
  // Loads are two short of the wait: one cycle is the accept, one is the exit edge.
  localparam logic [WAIT_W-1:0] TRP_LOAD   = WAIT_W'(TRP_CLK - 2);
  localparam logic [WAIT_W-1:0] TRFC_LOAD  = WAIT_W'(TRFC_CLK - 2);
  localparam logic [PEND_W-1:0] OWED_SAT   = PEND_W'(MAX_POSTPONE + 1);
  localparam logic [PEND_W-1:0] URGENT_LVL = PEND_W'(URGENT_TH);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_REQ      = 3'd1;
  localparam logic [2:0] ST_PREA     = 3'd2;
  localparam logic [2:0] ST_WAIT_RP  = 3'd3;
  localparam logic [2:0] ST_REF      = 3'd4;
  localparam logic [2:0] ST_WAIT_RFC = 3'd5;

  logic [2:0]        state, state_nxt;
  logic [CNT_W-1:0]  intv_cnt;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;
  logic [PEND_W-1:0] owed, owed_nxt;
  logic              tick;
  logic              prea_acc;
  logic              ref_acc;
  logic              ovf_set;

  assign tick     = ddr_init_done && (intv_cnt == TREFI_LAST);
  assign prea_acc = (state == ST_PREA) && ref_cmd_valid && ref_cmd_ready;
  assign ref_acc  = (state == ST_REF) && ref_cmd_valid && ref_cmd_ready;
  assign ref_pending = owed;

  // A tick coinciding with a REF accept cancels out, even at saturation.
  always_comb begin
    owed_nxt = owed;
    ovf_set  = 1'b0;
    if (!ddr_init_done) begin
      owed_nxt = '0;
    end else if (tick && !ref_acc) begin
      if (owed == OWED_SAT) ovf_set = 1'b1;
      else                  owed_nxt = owed + 1'b1;
    end else if (!tick && ref_acc) begin
      owed_nxt = owed - 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    if (!ddr_init_done) begin
      state_nxt = ST_IDLE;
      wait_nxt  = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (owed != '0) state_nxt = ST_REQ;
        end
        ST_REQ: begin
          if (ref_gnt) state_nxt = ST_PREA;
        end
        ST_PREA: begin
          if (prea_acc) begin
            state_nxt = ST_WAIT_RP;
            wait_nxt  = TRP_LOAD;
          end
        end
        ST_WAIT_RP: begin
          if (wait_cnt == '0) state_nxt = ST_REF;
          else                wait_nxt  = wait_cnt - 1'b1;
        end
        ST_REF: begin
          if (ref_acc) begin
            state_nxt = ST_WAIT_RFC;
            wait_nxt  = TRFC_LOAD;
          end
        end
        ST_WAIT_RFC: begin
          // Banks stay precharged and the grant is held, so back-to-back REFs skip PREA.
          if (wait_cnt == '0) state_nxt = (owed != '0) ? ST_REF : ST_IDLE;
          else                wait_nxt  = wait_cnt - 1'b1;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge core_clk or posedge core_arst) begin
    if (core_arst) begin
      state         <= ST_IDLE;
      wait_cnt      <= '0;
      intv_cnt      <= '0;
      owed          <= '0;
      ref_req       <= 1'b0;
      ref_urgent    <= 1'b0;
      ref_cmd_valid <= 1'b0;
      ref_cmd_type  <= 1'b0;
      ref_overflow  <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      if (!ddr_init_done || (intv_cnt == TREFI_LAST)) intv_cnt <= '0;
      else                                            intv_cnt <= intv_cnt + 1'b1;
      owed          <= owed_nxt;
      ref_urgent    <= (owed_nxt >= URGENT_LVL);
      ref_overflow  <= ref_overflow | ovf_set;
      ref_req       <= (state_nxt != ST_IDLE);
      ref_cmd_valid <= (state_nxt == ST_PREA) || (state_nxt == ST_REF);
      ref_cmd_type  <= (state_nxt == ST_REF);
    end
  end

endmodule

// File: tb/tb_refresh_control.sv
// Bench for refresh_control: directed scenarios push expected commands into a
// scoreboard; a monitor pops and checks every accepted command.
module tb_refresh_control;

  localparam int TREFI_CLK    = 100;
  localparam int TRP_CLK      = 5;
  localparam int TRFC_CLK     = 20;
  localparam int MAX_POSTPONE = 8;
  localparam int URGENT_TH    = 4;

  logic       core_clk = 1'b0;
  logic       core_arst = 1'b1;
  logic       ddr_init_done = 1'b0;
  logic       ref_gnt = 1'b0;
  logic       ref_cmd_ready = 1'b0;
  logic       ref_req;
  logic       ref_urgent;
  logic       ref_cmd_valid;
  logic       ref_cmd_type;
  logic [3:0] ref_pending;
  logic       ref_overflow;

  refresh_control #(
    .TREFI_CLK(TREFI_CLK), .TRP_CLK(TRP_CLK), .TRFC_CLK(TRFC_CLK),
    .MAX_POSTPONE(MAX_POSTPONE), .URGENT_TH(URGENT_TH)
  ) dut (
    .core_clk(core_clk), .core_arst(core_arst), .ddr_init_done(ddr_init_done),
    .ref_req(ref_req), .ref_urgent(ref_urgent), .ref_gnt(ref_gnt),
    .ref_cmd_valid(ref_cmd_valid), .ref_cmd_type(ref_cmd_type),
    .ref_cmd_ready(ref_cmd_ready), .ref_pending(ref_pending),
    .ref_overflow(ref_overflow)
  );

  always #5 core_clk = ~core_clk;

  int cyc = 0;
  always @(posedge core_clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  int t0 = 0;

  typedef struct {
    logic typ;
    int   cyc;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc - t0);
    end
  endtask

  task automatic push(input logic typ, input int off);
    exp_t e;
    e.typ = typ;
    e.cyc = t0 + off;
    sb.push_back(e);
  endtask

  task automatic at(input int off);
    while (cyc < t0 + off) @(negedge core_clk);
  endtask

  task automatic start();
    @(negedge core_clk);
    t0 = cyc;
    ddr_init_done = 1'b1;
  endtask

  // Monitor: every accepted command must match the head of the scoreboard.
  always @(negedge core_clk) begin
    exp_t e;
    #1;
    if (!core_arst && ref_cmd_valid && ref_cmd_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL cmd_unexpected: got type %0d at cycle %0d, required no command",
                 ref_cmd_type, cyc - t0);
      end else begin
        e = sb.pop_front();
        check("cmd_type", int'(ref_cmd_type), int'(e.typ));
        check("cmd_cycle", cyc - t0, e.cyc - t0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge core_clk);
    check("rst_req", int'(ref_req), 0);
    check("rst_valid", int'(ref_cmd_valid), 0);
    check("rst_type", int'(ref_cmd_type), 0);
    check("rst_pending", int'(ref_pending), 0);
    check("rst_urgent", int'(ref_urgent), 0);
    check("rst_overflow", int'(ref_overflow), 0);
    core_arst = 1'b0;

    // Basic: grant and ready always on.
    ref_gnt = 1'b1; ref_cmd_ready = 1'b1;
    start();
    push(1'b0, 102); push(1'b1, 107);
    at(99);  check("basic_pend_pre", int'(ref_pending), 0);
    at(100); check("basic_pend_tick", int'(ref_pending), 1);
             check("basic_req_pre", int'(ref_req), 0);
    at(101); check("basic_req_on", int'(ref_req), 1);
    at(107); check("basic_pend_ref", int'(ref_pending), 1);
    at(108); check("basic_pend_dec", int'(ref_pending), 0);
    at(126); check("basic_req_hold", int'(ref_req), 1);
    at(127); check("basic_req_off", int'(ref_req), 0);
             check("basic_urgent", int'(ref_urgent), 0);
    at(130); ddr_init_done = 1'b0;
    repeat (5) @(negedge core_clk);

    // Postpone: grant released before the fifth tick so the drain is exactly four REFs.
    ref_gnt = 1'b0;
    start();
    push(1'b0, 406);
    for (int i = 0; i < 4; i++) push(1'b1, 411 + 20 * i);
    at(101); check("post_req", int'(ref_req), 1);
    at(399); check("post_pend3", int'(ref_pending), 3);
             check("post_urg_off", int'(ref_urgent), 0);
    at(400); check("post_pend4", int'(ref_pending), 4);
             check("post_urg_on", int'(ref_urgent), 1);
    at(405); ref_gnt = 1'b1;
    at(412); check("post_pend_dec", int'(ref_pending), 3);
             check("post_urg_drop", int'(ref_urgent), 0);
    at(472); check("post_pend0", int'(ref_pending), 0);
    at(490); check("post_req_hold", int'(ref_req), 1);
    at(491); check("post_req_off", int'(ref_req), 0);
    at(495); ddr_init_done = 1'b0;
    repeat (5) @(negedge core_clk);

    // Overflow: ticks at 1100 and 1200 land inside the drain, so 11 REFs back to back.
    ref_gnt = 1'b0;
    start();
    push(1'b0, 1006);
    for (int i = 0; i < 11; i++) push(1'b1, 1011 + 20 * i);
    at(900);  check("ovf_pend9", int'(ref_pending), 9);
              check("ovf_pre", int'(ref_overflow), 0);
    at(999);  check("ovf_pre2", int'(ref_overflow), 0);
    at(1000); check("ovf_pend_sat", int'(ref_pending), 9);
              check("ovf_set", int'(ref_overflow), 1);
              check("ovf_urgent", int'(ref_urgent), 1);
    at(1005); ref_gnt = 1'b1;
    at(1100); check("ovf_pend_mid", int'(ref_pending), 5);
    at(1230); check("ovf_req_hold", int'(ref_req), 1);
    at(1231); check("ovf_req_off", int'(ref_req), 0);
              check("ovf_pend0", int'(ref_pending), 0);
              check("ovf_sticky", int'(ref_overflow), 1);
    at(1235); ddr_init_done = 1'b0;
    at(1240); check("ovf_keep_on_drop", int'(ref_overflow), 1);
    @(negedge core_clk);
    core_arst = 1'b1;
    #1 check("ovf_clr_rst", int'(ref_overflow), 0);
    @(negedge core_clk);
    core_arst = 1'b0;
    repeat (3) @(negedge core_clk);

    // Backpressure: ready low for 7 cycles in PREA and in REF.
    ref_gnt = 1'b1; ref_cmd_ready = 1'b0;
    start();
    push(1'b0, 109); push(1'b1, 121);
    for (int c = 102; c <= 108; c++) begin
      at(c);
      check("bp_prea_valid", int'(ref_cmd_valid), 1);
      check("bp_prea_type", int'(ref_cmd_type), 0);
    end
    at(109); ref_cmd_ready = 1'b1;
    at(110); ref_cmd_ready = 1'b0;
             check("bp_rp_valid", int'(ref_cmd_valid), 0);
    at(113); check("bp_rp_end", int'(ref_cmd_valid), 0);
    for (int c = 114; c <= 120; c++) begin
      at(c);
      check("bp_ref_valid", int'(ref_cmd_valid), 1);
      check("bp_ref_type", int'(ref_cmd_type), 1);
    end
    check("bp_pend_held", int'(ref_pending), 1);
    at(121); ref_cmd_ready = 1'b1;
    at(122); check("bp_pend0", int'(ref_pending), 0);
    at(140); check("bp_req_hold", int'(ref_req), 1);
    at(141); check("bp_req_off", int'(ref_req), 0);
    at(145); ddr_init_done = 1'b0;
    repeat (5) @(negedge core_clk);

    // Simultaneous: second REF accept coincides with the tick at 400.
    ref_gnt = 1'b0; ref_cmd_ready = 1'b1;
    start();
    push(1'b0, 374);
    for (int i = 0; i < 4; i++) push(1'b1, 379 + 20 * i);
    at(300); check("sim_pend3", int'(ref_pending), 3);
    at(373); ref_gnt = 1'b1;
    at(380); check("sim_pend_dec", int'(ref_pending), 2);
    at(399); check("sim_pend_pre", int'(ref_pending), 2);
    at(400); check("sim_pend_same", int'(ref_pending), 2);
    at(401); check("sim_pend_after", int'(ref_pending), 2);
    at(420); check("sim_pend1", int'(ref_pending), 1);
    at(440); check("sim_pend0", int'(ref_pending), 0);
    at(458); check("sim_req_hold", int'(ref_req), 1);
    at(459); check("sim_req_off", int'(ref_req), 0);
    at(465); ddr_init_done = 1'b0;
    repeat (5) @(negedge core_clk);

    // Abort: init_done drops during WAIT_RP; no REF may follow.
    ref_gnt = 1'b1; ref_cmd_ready = 1'b1;
    start();
    push(1'b0, 102);
    at(104); check("abt_pend_pre", int'(ref_pending), 1);
             ddr_init_done = 1'b0;
    at(105); check("abt_req", int'(ref_req), 0);
             check("abt_valid", int'(ref_cmd_valid), 0);
             check("abt_pend", int'(ref_pending), 0);
    at(112); check("abt_valid_late", int'(ref_cmd_valid), 0);
    t0 = cyc;
    ddr_init_done = 1'b1;
    push(1'b0, 102); push(1'b1, 107);
    at(99);  check("abt_restart_pre", int'(ref_pending), 0);
    at(100); check("abt_restart_tick", int'(ref_pending), 1);
    at(109); check("abt_restart_pend0", int'(ref_pending), 0);
    at(110); ddr_init_done = 1'b0;
    at(112); check("abt_rfc_drop_req", int'(ref_req), 0);
    repeat (30) @(negedge core_clk);

    check("sb_leftover", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
